sram_block_ctrl: RTL and testbench
==================================

# sram_block_ctrl

Controller and arbiter for the 8-byte key/data SRAM in the I2C Triple-DES design. It shares the SRAM's single byte port between the I2C slave, which does single-byte reads and writes, and the DES core, which loads and stores whole 64-bit blocks. It sequences each block transfer as 8 consecutive byte accesses.

## Interface
Parameters:
- none (SRAM geometry is fixed: byte addresses 16'h0001–16'h0008; address k holds block bits [8k-1:8k-8])

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset; asynchronous, active-high (asserted when 1)
- i2c_req  in  1  level request for one byte access, held until i2c_ack
- i2c_rw  in  1  1 = write, 0 = read
- i2c_addr  in  16  byte address
- i2c_wdata  in  8  write byte
- i2c_ack  out  1  one-cycle completion pulse
- i2c_rdata  out  8  read byte, valid while i2c_ack = 1
- i2c_err  out  1  address outside 1..8, valid while i2c_ack = 1
- des_load_req  in  1  level request to read the full 64-bit block
- des_store_req  in  1  level request to write des_block_in
- des_block_in  in  64  block to store, sampled at grant
- des_block_out  out  64  assembled block, updated at load completion
- des_load_done  out  1  one-cycle pulse
- des_store_done  out  1  one-cycle pulse
- busy  out  1  high in every state except IDLE
- sram_read_enable  out  1  to SRAM
- sram_write_enable  out  1  to SRAM
- sram_address  out  16  to SRAM
- sram_write_data  out  8  to SRAM
- sram_read_data  in  8  from SRAM, combinational on address/read_enable

## Operation
- FSM states:
  - IDLE: evaluate requests.
  - I2C: 1 access cycle.
  - BLK_RD: 8 access cycles.
  - BLK_WR: 8 access cycles.
  - DONE: 1 cycle; pulse the completion output.
  - DONE always returns to IDLE.
- Arbitration in IDLE, between 2 requesters:
  - I2C requester: i2c_req.
  - DES requester: des_load_req or des_store_req.
- Tie-break is round-robin: the requester not granted last wins. The last-grant pointer resets to I2C, so DES wins the first tie.
- Within DES, des_store_req has priority over des_load_req when both are high.
- Operations are non-preemptible. Requests arriving mid-operation wait for IDLE.
- I2C access:
  - Valid address: drive sram_address = i2c_addr.
  - Write: sram_write_enable = 1, sram_write_data = i2c_wdata.
  - Read: sram_read_enable = 1; capture sram_read_data into i2c_rdata.
  - Invalid address (0 or >8): no enable asserted, i2c_rdata = 8'h00, i2c_err = 1.
- Block read: addresses 1..8 ascending, one per cycle. Byte from address k goes into shadow bits [8k-1:8k-8]. The shadow is copied to des_block_out on entry to DONE.
- Block write:
  - des_block_in is snapshotted at the grant edge; later changes are ignored.
  - Addresses 1..8 ascending; byte k = snapshot[8k-1:8k-8].
- All sram_* outputs are registered.
- Outside access cycles: sram_address = 16'h0000 (matches no location), both enables 0, write_data 8'h00.
- A 4-bit byte counter runs 0..7, maps to address counter+1, and exits the block state at 7.
- Reset values:
  - all outputs 0;
  - des_block_out 64'h0;
  - state IDLE;
  - counter 0;
  - pointer I2C.
- Reset mid-operation:
  - enables drop immediately (asynchronous);
  - partial shadow is discarded;
  - no done/ack pulse;
  - des_block_out is cleared.

## Timing
- Requests are sampled in IDLE cycle T.
- I2C access:
  - SRAM access in T+1;
  - i2c_ack, i2c_rdata, i2c_err in T+2;
  - IDLE again at T+3.
- Block op:
  - accesses in T+1..T+8;
  - done pulse in T+9;
  - IDLE at T+10.
- Read data is sampled at the rising edge that ends the access cycle.
- Requesters must drop req on the edge that ends the ack/done cycle. A req still high in the following IDLE cycle is a new request.
- Back-to-back: with both requesters continuously pending, grants alternate DES, I2C, DES, …, with one IDLE cycle between operations.
- busy = 1 from T+1 through the DONE cycle inclusive.

## Test plan
- Reset, then I2C write addr 3 data 8'hA5, then I2C read addr 3:
  - write ack at T+2;
  - read returns i2c_rdata = 8'hA5, i2c_err = 0;
  - sram_address = 16'h0003 during each access cycle.
- des_store_req with block 64'h0807060504030201, then des_load_req:
  - store writes bytes 01..08 to addresses 1..8 in 8 consecutive cycles;
  - des_store_done at T+9;
  - load yields des_block_out = 64'h0807060504030201 with des_load_done at T+9.
- I2C read addr 16'h0009 and addr 16'h0000:
  - no SRAM enable asserted;
  - ack with i2c_err = 1, i2c_rdata = 8'h00.
- i2c_req and des_load_req asserted together from reset, held:
  - DES granted first, then I2C;
  - des_store_req raised during the I2C op is served next.
- des_block_in changed during BLK_WR: written bytes match the grant-edge value.
- n_rst asserted at the 4th byte of a block load:
  - enables fall immediately;
  - no des_load_done;
  - des_block_out = 0;
  - after release, a fresh load completes normally.

Source files
------------

// File: rtl/sram_block_ctrl.sv
// Arbiter/sequencer sharing the 8-byte key/data SRAM port between the I2C slave
// (single-byte accesses) and the DES core (whole 64-bit block loads/stores).
module sram_block_ctrl (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i2c_req,
  input  logic        i2c_rw,
  input  logic [15:0] i2c_addr,
  input  logic [7:0]  i2c_wdata,
  output logic        i2c_ack,
  output logic [7:0]  i2c_rdata,
  output logic        i2c_err,
  input  logic        des_load_req,
  input  logic        des_store_req,
  input  logic [63:0] des_block_in,
  output logic [63:0] des_block_out,
  output logic        des_load_done,
  output logic        des_store_done,
  output logic        busy,
  output logic        sram_read_enable,
  output logic        sram_write_enable,
  output logic [15:0] sram_address,
  output logic [7:0]  sram_write_data,
  input  logic [7:0]  sram_read_data
);

  typedef enum logic [2:0] {IDLE, I2C, BLK_RD, BLK_WR, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_des_q, last_des_d;
  logic [7:0][7:0]  blk_q, blk_d;
  logic             err_q, err_d;
  logic             ack_q, ack_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_out_q, err_out_d;
  logic             ld_done_q, ld_done_d;
  logic             st_done_q, st_done_d;
  logic [63:0]      blk_out_q, blk_out_d;
  logic             re_q, re_d, we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wd_q, wd_d;

  logic       des_req, grant_des, grant_i2c, i2c_ok;
  logic [2:0] idx, nidx;

  assign des_req   = des_load_req | des_store_req;
  // Round-robin tie-break: on a tie, the side not granted last wins.
  assign grant_des = des_req & (~i2c_req | ~last_des_q);
  assign grant_i2c = i2c_req & ~grant_des;
  assign i2c_ok    = (i2c_addr != 16'h0000) && (i2c_addr <= 16'd8);
  assign idx       = cnt_q[2:0];
  assign nidx      = idx + 3'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_des_d = last_des_q;
    blk_d      = blk_q;
    err_d      = err_q;
    ack_d      = 1'b0;
    rdata_d    = 8'h00;
    err_out_d  = 1'b0;
    ld_done_d  = 1'b0;
    st_done_d  = 1'b0;
    blk_out_d  = blk_out_q;
    re_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = 16'h0000;
    wd_d       = 8'h00;
    case (state_q)
      IDLE: begin
        if (grant_des) begin
          last_des_d = 1'b1;
          cnt_d      = 4'd0;
          addr_d     = 16'h0001;
          if (des_store_req) begin
            state_d = BLK_WR;
            blk_d   = des_block_in;
            we_d    = 1'b1;
            wd_d    = des_block_in[7:0];
          end else begin
            state_d = BLK_RD;
            re_d    = 1'b1;
          end
        end else if (grant_i2c) begin
          last_des_d = 1'b0;
          state_d    = I2C;
          err_d      = ~i2c_ok;
          if (i2c_ok) begin
            addr_d = i2c_addr;
            we_d   = i2c_rw;
            re_d   = ~i2c_rw;
            wd_d   = i2c_rw ? i2c_wdata : 8'h00;
          end
        end
      end
      I2C: begin
        state_d   = DONE;
        ack_d     = 1'b1;
        rdata_d   = re_q ? sram_read_data : 8'h00;
        err_out_d = err_q;
      end
      BLK_RD: begin
        blk_d[idx] = sram_read_data;
        if (cnt_q == 4'd7) begin
          state_d   = DONE;
          ld_done_d = 1'b1;
          blk_out_d = blk_d;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          re_d   = 1'b1;
          addr_d = {12'h000, cnt_q + 4'd2};
        end
      end
      BLK_WR: begin
        if (cnt_q == 4'd7) begin
          state_d   = DONE;
          st_done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          we_d   = 1'b1;
          addr_d = {12'h000, cnt_q + 4'd2};
          wd_d   = blk_q[nidx];
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      last_des_q <= 1'b0;
      blk_q      <= '0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= 8'h00;
      err_out_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      blk_out_q  <= 64'h0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wd_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_des_q <= last_des_d;
      blk_q      <= blk_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      err_out_q  <= err_out_d;
      ld_done_q  <= ld_done_d;
      st_done_q  <= st_done_d;
      blk_out_q  <= blk_out_d;
      re_q       <= re_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign i2c_ack           = ack_q;
  assign i2c_rdata         = rdata_q;
  assign i2c_err           = err_out_q;
  assign des_block_out     = blk_out_q;
  assign des_load_done     = ld_done_q;
  assign des_store_done    = st_done_q;
  assign sram_read_enable  = re_q;
  assign sram_write_enable = we_q;
  assign sram_address      = addr_q;
  assign sram_write_data   = wd_q;

endmodule

// File: tb/tb_sram_block_ctrl.sv
// Bench for sram_block_ctrl: behavioural SRAM plus an 8-byte memory model,
// directed scenarios followed by a randomized mix of I2C and block operations.
module tb_sram_block_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i2c_req, i2c_rw;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_wdata;
  logic        i2c_ack, i2c_err;
  logic [7:0]  i2c_rdata;
  logic        des_load_req, des_store_req;
  logic [63:0] des_block_in, des_block_out;
  logic        des_load_done, des_store_done, busy;
  logic        sram_read_enable, sram_write_enable;
  logic [15:0] sram_address;
  logic [7:0]  sram_write_data, sram_read_data;

  logic [7:0]  sram_mem [1:8] = '{default: 8'h00};
  logic [7:0]  mem_model [1:8];
  logic [63:0] exp_out;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sram_block_ctrl dut (
    .clk(clk), .n_rst(n_rst),
    .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata), .i2c_err(i2c_err),
    .des_load_req(des_load_req), .des_store_req(des_store_req),
    .des_block_in(des_block_in), .des_block_out(des_block_out),
    .des_load_done(des_load_done), .des_store_done(des_store_done), .busy(busy),
    .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data)
  );

  wire in_range = (sram_address >= 16'd1) && (sram_address <= 16'd8);
  assign sram_read_data = (sram_read_enable && in_range) ? sram_mem[sram_address[3:0]] : 8'h00;
  always @(posedge clk) if (sram_write_enable && in_range) sram_mem[sram_address[3:0]] <= sram_write_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_block();
    logic [63:0] r;
    for (int k = 1; k <= 8; k++) r[8*k-1 -: 8] = mem_model[k];
    return r;
  endfunction

  task automatic do_i2c(input logic rw, input logic [15:0] a, input logic [7:0] wd);
    logic       ok;
    logic [7:0] exp_rd;
    ok = (a >= 16'd1) && (a <= 16'd8);
    exp_rd = (ok && !rw) ? mem_model[a[3:0]] : 8'h00;
    i2c_rw = rw; i2c_addr = a; i2c_wdata = wd; i2c_req = 1'b1;
    @(posedge clk); #1;
    chk("i2c_addr", 64'(sram_address), ok ? 64'(a) : 64'h0);
    chk("i2c_we", 64'(sram_write_enable), 64'(ok && rw));
    chk("i2c_re", 64'(sram_read_enable), 64'(ok && !rw));
    chk("i2c_wd", 64'(sram_write_data), (ok && rw) ? 64'(wd) : 64'h0);
    chk("i2c_busy", 64'(busy), 64'h1);
    if (ok && rw) mem_model[a[3:0]] = wd;
    @(posedge clk); #1;
    chk("i2c_ack", 64'(i2c_ack), 64'h1);
    chk("i2c_rdata", 64'(i2c_rdata), 64'(exp_rd));
    chk("i2c_err", 64'(i2c_err), 64'(!ok));
    i2c_req = 1'b0;
    @(posedge clk); #1;
    chk("i2c_ack_end", 64'(i2c_ack), 64'h0);
    chk("i2c_idle", 64'(busy), 64'h0);
  endtask

  task automatic do_blk(input logic store, input logic [63:0] blk);
    if (store) begin des_block_in = blk; des_store_req = 1'b1; end
    else des_load_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (store) des_block_in = {$urandom, $urandom};
      chk("blk_addr", 64'(sram_address), 64'(k));
      chk("blk_we", 64'(sram_write_enable), 64'(store));
      chk("blk_re", 64'(sram_read_enable), 64'(!store));
      chk("blk_wd", 64'(sram_write_data), store ? 64'(blk[8*k-1 -: 8]) : 64'h0);
    end
    if (store) for (int k = 1; k <= 8; k++) mem_model[k] = blk[8*k-1 -: 8];
    else exp_out = model_block();
    @(posedge clk); #1;
    chk("blk_st_done", 64'(des_store_done), 64'(store));
    chk("blk_ld_done", 64'(des_load_done), 64'(!store));
    chk("blk_out", des_block_out, exp_out);
    chk("blk_busy", 64'(busy), 64'h1);
    des_store_req = 1'b0; des_load_req = 1'b0;
    @(posedge clk); #1;
    chk("blk_done_end", 64'({des_store_done, des_load_done}), 64'h0);
    chk("blk_idle", 64'(busy), 64'h0);
  endtask

  // Waits (bounded) for the next completion pulse: 1 = i2c ack, 2 = load, 3 = store, 0 = none.
  task automatic wait_evt(output int code);
    code = 0;
    for (int i = 0; i < 40 && code == 0; i++) begin
      @(posedge clk); #1;
      if (i2c_ack) code = 1;
      else if (des_load_done) code = 2;
      else if (des_store_done) code = 3;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_outs", 64'({i2c_ack, i2c_err, des_load_done, des_store_done, busy,
                         sram_read_enable, sram_write_enable}), 64'h0);
    chk("rst_bus", 64'({i2c_rdata, sram_address, sram_write_data}), 64'h0);
    chk("rst_blk", des_block_out, 64'h0);
    exp_out = 64'h0;
    n_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int code, cnt;
    logic [63:0] b;
    n_rst = 1'b0; i2c_req = 1'b0; i2c_rw = 1'b0; i2c_addr = 16'h0; i2c_wdata = 8'h0;
    des_load_req = 1'b0; des_store_req = 1'b0; des_block_in = 64'h0;
    for (int k = 1; k <= 8; k++) mem_model[k] = 8'h00;
    exp_out = 64'h0;
    apply_reset();

    do_i2c(1'b1, 16'h0003, 8'hA5);
    do_i2c(1'b0, 16'h0003, 8'h00);
    chk("rd_a5", 64'(i2c_rdata), 64'h0);
    do_blk(1'b1, 64'h0807060504030201);
    do_blk(1'b0, 64'h0);
    chk("load_val", des_block_out, 64'h0807060504030201);
    do_i2c(1'b0, 16'h0009, 8'h00);
    do_i2c(1'b0, 16'h0000, 8'h00);
    do_i2c(1'b1, 16'h0100, 8'h77);
    do_i2c(1'b0, 16'h0008, 8'h00);

    // Reset during the 4th byte of a block load.
    des_load_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_addr4", 64'(sram_address), 64'h4);
    #2 n_rst = 1'b1;
    #1;
    chk("mid_re", 64'(sram_read_enable), 64'h0);
    chk("mid_addr", 64'(sram_address), 64'h0);
    chk("mid_busy", 64'(busy), 64'h0);
    chk("mid_blk", des_block_out, 64'h0);
    exp_out = 64'h0;
    des_load_req = 1'b0;
    @(posedge clk); #1 n_rst = 1'b0;
    cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (des_load_done) cnt++; end
    chk("mid_no_done", 64'(cnt), 64'h0);
    do_blk(1'b0, 64'h0);

    // Arbitration from reset: tie goes to DES first, then I2C, then a late store.
    apply_reset();
    i2c_rw = 1'b0; i2c_addr = 16'h0005; i2c_req = 1'b1; des_load_req = 1'b1;
    @(posedge clk); #1;
    chk("arb_first_re", 64'(sram_read_enable), 64'h1);
    chk("arb_first_addr", 64'(sram_address), 64'h1);
    wait_evt(code);
    chk("arb_load", 64'(code), 64'h2);
    exp_out = model_block();
    chk("arb_load_val", des_block_out, exp_out);
    des_load_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("arb_i2c_addr", 64'(sram_address), 64'h5);
    b = 64'hDEADBEEF_0BADF00D;
    des_block_in = b; des_store_req = 1'b1;
    wait_evt(code);
    chk("arb_i2c", 64'(code), 64'h1);
    chk("arb_i2c_rd", 64'(i2c_rdata), 64'(mem_model[5]));
    i2c_req = 1'b0;
    wait_evt(code);
    chk("arb_store", 64'(code), 64'h3);
    for (int k = 1; k <= 8; k++) mem_model[k] = b[8*k-1 -: 8];
    des_store_req = 1'b0;
    // DES was granted last, so this tie goes to I2C.
    i2c_rw = 1'b1; i2c_addr = 16'h0002; i2c_wdata = 8'h3C; i2c_req = 1'b1; des_load_req = 1'b1;
    wait_evt(code);
    chk("tie_i2c", 64'(code), 64'h1);
    mem_model[2] = 8'h3C;
    i2c_req = 1'b0;
    wait_evt(code);
    chk("tie_load", 64'(code), 64'h2);
    exp_out = model_block();
    chk("tie_load_val", des_block_out, exp_out);
    des_load_req = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: do_i2c(1'b1, 16'($urandom_range(0, 10)), 8'($urandom));
        1: do_i2c(1'b0, 16'($urandom_range(0, 10)), 8'h00);
        2: do_blk(1'b1, {$urandom, $urandom});
        default: do_blk(1'b0, 64'h0);
      endcase
    end
    do_blk(1'b0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
